// File: rtl/bcd_display_ctrl_if.sv
// ---------------------------------------------------------------------------
// bcd_display_ctrl_if
// Bundle of request/status signals between a display front end (master) and
// the BCD display sequencing controller (slave).
//   i_bin      : value to display
//   i_mode     : 0 = hex, 1 = decimal
//   i_blank_en : 1 = blank leading zero digits
//   i_start    : conversion request
//   i_auto     : self-start when {i_mode,i_bin} changes
//   o_busy     : controller not idle
//   o_done     : one-cycle pulse, o_digits/o_blank freshly updated
//   o_digits   : digit nibbles, [3:0] = least significant digit
//   o_blank    : bit k = 1 -> decoder k drives segments off
// ---------------------------------------------------------------------------
interface bcd_display_ctrl_if #(
  parameter int W_IN  = 8,
  parameter int N_DIG = 3
);
  logic [W_IN-1:0]    i_bin;
  logic               i_mode;
  logic               i_blank_en;
  logic               i_start;
  logic               i_auto;
  logic               o_busy;
  logic               o_done;
  logic [N_DIG*4-1:0] o_digits;
  logic [N_DIG-1:0]   o_blank;

  // Controller side
  modport slave (
    input  i_bin, i_mode, i_blank_en, i_start, i_auto,
    output o_busy, o_done, o_digits, o_blank
  );

  // Requester side
  modport master (
    output i_bin, i_mode, i_blank_en, i_start, i_auto,
    input  o_busy, o_done, o_digits, o_blank
  );
endinterface

// File: rtl/bcd_display_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_display_ctrl
// Captures a binary switch value and a hex/decimal mode, optionally runs an
// iterative shift-add-3 (double-dabble) conversion one bit per clock, then
// publishes a registered digit word plus leading-zero blank flags in a single
// atomic update.
// Ports:
//   i_clk : system clock
//   i_rst : synchronous, active-high reset
//   bus   : bcd_display_ctrl_if.slave (inputs i_*, outputs o_*)
// ---------------------------------------------------------------------------
module bcd_display_ctrl #(
  parameter int W_IN  = 8,
  parameter int N_DIG = 3
) (
  input logic                 i_clk,
  input logic                 i_rst,
  bcd_display_ctrl_if.slave   bus
);

  localparam int DW = N_DIG * 4;
  localparam int CW = (W_IN > 1) ? $clog2(W_IN) : 1;
  localparam logic [CW-1:0] LAST_SHIFT = CW'(W_IN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    PUB  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [DW-1:0]   r_scratch;
  logic [W_IN-1:0] r_shadow_bin;
  logic            r_shadow_mode;
  logic            r_shadow_blank_en;
  logic [W_IN:0]   r_last;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_digits;
  logic [N_DIG-1:0] r_blank;
  logic            r_done;

  logic            w_trigger;
  logic [DW-1:0]   w_adj;
  logic [DW-1:0]   w_shifted;
  logic [DW-1:0]   w_pub_digits;
  logic [N_DIG-1:0] w_pub_blank;

  // Auto-start compares against the last captured request, so a change made
  // while busy is still seen once the controller returns to IDLE.
  assign w_trigger = bus.i_start ||
                     (bus.i_auto && ({bus.i_mode, bus.i_bin} != r_last));

  // Add-3 correction: every nibble is tested on its pre-add value in parallel.
  generate
    for (genvar gi = 0; gi < N_DIG; gi++) begin : g_adj
      assign w_adj[gi*4 +: 4] = (r_scratch[gi*4 +: 4] >= 4'd5) ?
                                (r_scratch[gi*4 +: 4] + 4'd3) :
                                r_scratch[gi*4 +: 4];
    end
  endgenerate

  // Shift {scratch,shadow} left by one; shadow MSB enters scratch LSB.
  assign w_shifted = {w_adj[DW-2:0], r_shadow_bin[W_IN-1]};

  assign w_pub_digits = r_shadow_mode ? r_scratch
                                      : {{(DW-W_IN){1'b0}}, r_shadow_bin};

  // Digit k is blanked only if it and every more significant digit are zero;
  // the units digit always shows so a zero value still reads "0".
  assign w_pub_blank[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < N_DIG; gi++) begin : g_blank
      assign w_pub_blank[gi] = r_shadow_blank_en &&
                               (w_pub_digits[DW-1:gi*4] == '0);
    end
  endgenerate

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_trigger) begin
          w_state_next = bus.i_mode ? CONV : PUB;
        end
      end
      CONV: begin
        if (r_cnt == LAST_SHIFT) begin
          w_state_next = PUB;
        end
      end
      PUB:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scratch         <= '0;
      r_shadow_bin      <= '0;
      r_shadow_mode     <= 1'b0;
      r_shadow_blank_en <= 1'b0;
      r_last            <= '0;
      r_cnt             <= '0;
      r_digits          <= '0;
      r_blank           <= '0;
      r_done            <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_shadow_bin      <= bus.i_bin;
            r_shadow_mode     <= bus.i_mode;
            r_shadow_blank_en <= bus.i_blank_en;
            r_last            <= {bus.i_mode, bus.i_bin};
            r_scratch         <= '0;
            r_cnt             <= '0;
          end
        end
        CONV: begin
          r_scratch    <= w_shifted;
          r_shadow_bin <= r_shadow_bin << 1;
          r_cnt        <= r_cnt + CW'(1);
        end
        PUB: begin
          r_digits <= w_pub_digits;
          r_blank  <= w_pub_blank;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy   = (r_state != IDLE);
  assign bus.o_done   = r_done;
  assign bus.o_digits = r_digits;
  assign bus.o_blank  = r_blank;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_display_ctrl
// Directed bench for bcd_display_ctrl; outputs are sampled 1 time unit after
// each rising edge. One line printed per conversion transaction.
// ---------------------------------------------------------------------------
module tb_bcd_display_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  bcd_display_ctrl_if #(.W_IN(8), .N_DIG(3)) u_if ();

  bcd_display_ctrl #(.W_IN(8), .N_DIG(3)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses i_start for one edge (E0) and counts edges up to and including the
  // one after which o_done is high. Returns 30 if o_done never appears.
  task automatic start_and_wait(input logic [7:0] bin, input logic mode,
                                input logic blank_en, output int edges);
    u_if.i_bin      = bin;
    u_if.i_mode     = mode;
    u_if.i_blank_en = blank_en;
    u_if.i_start    = 1'b1;
    tick();
    u_if.i_start = 1'b0;
    edges = 1;
    while (u_if.o_done !== 1'b1 && edges < 30) begin
      tick();
      edges++;
    end
    $display("txn bin=%0d mode=%0d blank_en=%0d edges=%0d digits=%h blank=%b",
             bin, mode, blank_en, edges, u_if.o_digits, u_if.o_blank);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    u_if.i_start = 1'b1;
    u_if.i_mode  = 1'b1;
    u_if.i_bin   = 8'd255;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (u_if.o_busy !== 1'b0 || u_if.o_done !== 1'b0 ||
          u_if.o_digits !== 12'h000 || u_if.o_blank !== 3'b000) begin
        n_errors++;
        $display("FAIL reset: busy=%b done=%b digits=%h blank=%b required 0 0 000 000",
                 u_if.o_busy, u_if.o_done, u_if.o_digits, u_if.o_blank);
      end
    end
    rst = 1'b0;
    u_if.i_start = 1'b0;
    tick();
    n_checks++;
    if (u_if.o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle: busy=%b required 0", u_if.o_busy);
    end
  endtask

  task automatic test_decimal_max();
    u_if.i_bin      = 8'd255;
    u_if.i_mode     = 1'b1;
    u_if.i_blank_en = 1'b0;
    u_if.i_start    = 1'b1;
    tick();  // E0
    u_if.i_start = 1'b0;
    for (int e = 0; e <= 8; e++) begin
      if (e > 0) tick();
      n_checks++;
      if (u_if.o_busy !== 1'b1 || u_if.o_done !== 1'b0) begin
        n_errors++;
        $display("FAIL dec_max_busy E%0d: busy=%b done=%b required 1 0",
                 e, u_if.o_busy, u_if.o_done);
      end
    end
    tick();  // E9
    $display("txn bin=255 mode=1 digits=%h blank=%b done=%b",
             u_if.o_digits, u_if.o_blank, u_if.o_done);
    n_checks++;
    if (u_if.o_done !== 1'b1 || u_if.o_busy !== 1'b0 ||
        u_if.o_digits !== 12'h255 || u_if.o_blank !== 3'b000) begin
      n_errors++;
      $display("FAIL dec_max_E9: done=%b busy=%b digits=%h blank=%b required 1 0 255 000",
               u_if.o_done, u_if.o_busy, u_if.o_digits, u_if.o_blank);
    end
    tick();  // E10
    n_checks++;
    if (u_if.o_done !== 1'b0 || u_if.o_digits !== 12'h255) begin
      n_errors++;
      $display("FAIL dec_max_E10: done=%b digits=%h required 0 255",
               u_if.o_done, u_if.o_digits);
    end
  endtask

  task automatic test_hex();
    int edges;
    start_and_wait(8'hA5, 1'b0, 1'b1, edges);
    n_checks++;
    if (edges !== 2 || u_if.o_digits !== 12'h0A5 || u_if.o_blank !== 3'b100) begin
      n_errors++;
      $display("FAIL hex_a5: edges=%0d digits=%h blank=%b required 2 0a5 100",
               edges, u_if.o_digits, u_if.o_blank);
    end
    tick();
    n_checks++;
    if (u_if.o_done !== 1'b0) begin
      n_errors++;
      $display("FAIL hex_done_pulse: done=%b required 0", u_if.o_done);
    end
    start_and_wait(8'hFF, 1'b0, 1'b0, edges);
    n_checks++;
    if (edges !== 2 || u_if.o_digits !== 12'h0FF || u_if.o_blank !== 3'b000) begin
      n_errors++;
      $display("FAIL hex_ff: edges=%0d digits=%h blank=%b required 2 0ff 000",
               edges, u_if.o_digits, u_if.o_blank);
    end
    tick();
  endtask

  task automatic test_blanking();
    logic [7:0]  v_bin   [5];
    logic        v_ben   [5];
    logic [11:0] v_dig   [5];
    logic [2:0]  v_blank [5];
    int edges;
    v_bin[0] = 8'd7;   v_ben[0] = 1'b1; v_dig[0] = 12'h007; v_blank[0] = 3'b110;
    v_bin[1] = 8'd0;   v_ben[1] = 1'b1; v_dig[1] = 12'h000; v_blank[1] = 3'b110;
    v_bin[2] = 8'd7;   v_ben[2] = 1'b0; v_dig[2] = 12'h007; v_blank[2] = 3'b000;
    v_bin[3] = 8'd0;   v_ben[3] = 1'b0; v_dig[3] = 12'h000; v_blank[3] = 3'b000;
    v_bin[4] = 8'd40;  v_ben[4] = 1'b1; v_dig[4] = 12'h040; v_blank[4] = 3'b100;
    for (int i = 0; i < 5; i++) begin
      start_and_wait(v_bin[i], 1'b1, v_ben[i], edges);
      n_checks++;
      if (edges !== 10 || u_if.o_digits !== v_dig[i] || u_if.o_blank !== v_blank[i]) begin
        n_errors++;
        $display("FAIL blank_case%0d: edges=%0d digits=%h blank=%b required 10 %h %b",
                 i, edges, u_if.o_digits, u_if.o_blank, v_dig[i], v_blank[i]);
      end
      tick();
    end
  endtask

  task automatic test_busy_auto();
    int dones;
    u_if.i_bin      = 8'd100;
    u_if.i_mode     = 1'b1;
    u_if.i_blank_en = 1'b0;
    u_if.i_start    = 1'b1;
    tick();  // E0
    dones = 0;
    for (int e = 1; e <= 20; e++) begin
      u_if.i_start = (e == 4);
      tick();
      if (u_if.o_done === 1'b1) dones++;
    end
    u_if.i_start = 1'b0;
    $display("txn bin=100 busy-start dones=%0d digits=%h", dones, u_if.o_digits);
    n_checks++;
    if (dones !== 1 || u_if.o_digits !== 12'h100) begin
      n_errors++;
      $display("FAIL busy_ignore: dones=%0d digits=%h required 1 100",
               dones, u_if.o_digits);
    end
    u_if.i_auto = 1'b1;
    u_if.i_bin  = 8'd42;
    dones = 0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (u_if.o_done === 1'b1) dones++;
    end
    $display("txn bin=42 auto dones=%0d digits=%h", dones, u_if.o_digits);
    n_checks++;
    if (dones !== 1 || u_if.o_digits !== 12'h042 || u_if.o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL auto: dones=%0d digits=%h busy=%b required 1 042 0",
               dones, u_if.o_digits, u_if.o_busy);
    end
    u_if.i_auto = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int dones;
    int edges;
    u_if.i_bin   = 8'd200;
    u_if.i_mode  = 1'b1;
    u_if.i_start = 1'b1;
    tick();  // E0
    u_if.i_start = 1'b0;
    for (int e = 1; e <= 4; e++) tick();
    rst = 1'b1;
    tick();  // E5
    rst = 1'b0;
    n_checks++;
    if (u_if.o_busy !== 1'b0 || u_if.o_done !== 1'b0 || u_if.o_digits !== 12'h000) begin
      n_errors++;
      $display("FAIL reset_mid: busy=%b done=%b digits=%h required 0 0 000",
               u_if.o_busy, u_if.o_done, u_if.o_digits);
    end
    dones = 0;
    for (int e = 0; e < 15; e++) begin
      tick();
      if (u_if.o_done === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 0) begin
      n_errors++;
      $display("FAIL reset_mid_nodone: dones=%0d required 0", dones);
    end
    start_and_wait(8'd200, 1'b1, 1'b0, edges);
    n_checks++;
    if (edges !== 10 || u_if.o_digits !== 12'h200) begin
      n_errors++;
      $display("FAIL reset_restart: edges=%0d digits=%h required 10 200",
               edges, u_if.o_digits);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int edges;
    start_and_wait(8'd128, 1'b1, 1'b1, edges);
    n_checks++;
    if (edges !== 10 || u_if.o_digits !== 12'h128 || u_if.o_blank !== 3'b000) begin
      n_errors++;
      $display("FAIL b2b_first: edges=%0d digits=%h blank=%b required 10 128 000",
               edges, u_if.o_digits, u_if.o_blank);
    end
    // New start in the same cycle o_done is high
    start_and_wait(8'd99, 1'b1, 1'b1, edges);
    n_checks++;
    if (edges !== 10 || u_if.o_digits !== 12'h099 || u_if.o_blank !== 3'b100) begin
      n_errors++;
      $display("FAIL b2b_second: edges=%0d digits=%h blank=%b required 10 099 100",
               edges, u_if.o_digits, u_if.o_blank);
    end
    tick();
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst             = 1'b1;
    u_if.i_bin      = 8'd0;
    u_if.i_mode     = 1'b0;
    u_if.i_blank_en = 1'b0;
    u_if.i_start    = 1'b0;
    u_if.i_auto     = 1'b0;
    test_reset();
    test_decimal_max();
    test_hex();
    test_blanking();
    test_busy_auto();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
